// File: rtl/tournament_pkg.sv
// Shared types and constants for the tournament chooser and its choice table.
// Ports: none (package).
// Counter constants are sized by CNT_BITS_DEF; CHOICE_INIT means "weakly prefer local".
package tournament_pkg;

    localparam int HIST_BITS_DEF = 12;
    localparam int CNT_BITS_DEF  = 2;
    localparam int MISP_BITS_DEF = 16;

    typedef logic [CNT_BITS_DEF-1:0] choice_cnt_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_RESOLVE = 2'd1,
        UPDATE       = 2'd2
    } chooser_state_t;

    localparam choice_cnt_t CHOICE_INIT = 2'b01;
    localparam choice_cnt_t CHOICE_MAX  = 2'b11;
    localparam choice_cnt_t CHOICE_MIN  = 2'b00;

endpackage

// File: rtl/choice_pht.sv
// Choice table: 2**HIST_BITS saturating counters, MSB=1 selects the global predictor.
// Ports: i_clock/i_rst_n (async active-low, every entry -> CHOICE_INIT);
//        i_rd_idx -> o_rd_msb (combinational); i_wr_en/i_wr_idx/i_wr_inc (inc=1, dec=0).
module choice_pht
    import tournament_pkg::*;
#(
    parameter int HIST_BITS = HIST_BITS_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_rst_n,
    input  logic [HIST_BITS-1:0] i_rd_idx,
    output logic                 o_rd_msb,
    input  logic                 i_wr_en,
    input  logic [HIST_BITS-1:0] i_wr_idx,
    input  logic                 i_wr_inc
);

    localparam int DEPTH = 1 << HIST_BITS;

    logic [CNT_BITS-1:0] r_cnt [DEPTH];
    logic [CNT_BITS-1:0] w_cur;

    assign o_rd_msb = r_cnt[i_rd_idx][CNT_BITS-1];
    assign w_cur    = r_cnt[i_wr_idx];

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= CHOICE_INIT;
            end
        end else if (i_wr_en) begin
            // Saturate at both ends rather than wrapping.
            if (i_wr_inc) begin
                if (w_cur != CHOICE_MAX) begin
                    r_cnt[i_wr_idx] <= w_cur + CNT_BITS'(1);
                end
            end else begin
                if (w_cur != CHOICE_MIN) begin
                    r_cnt[i_wr_idx] <= w_cur - CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tournament_chooser.sv
// Tournament chooser: picks local or global direction via a history-indexed choice table,
// owns the global path history and a saturating mispredict counter.
// Ports: clock/reset (async active-low); PredValid+LDresult/GDresult -> Prediction/PredictionValid
//        one cycle later; ResolveValid+BranchTaken trains; Busy, GlobalHistory, MispredictCount out.
module tournament_chooser
    import tournament_pkg::*;
#(
    parameter int HIST_BITS = HIST_BITS_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF,
    parameter int MISP_BITS = MISP_BITS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 PredValid,
    input  logic                 LDresult,
    input  logic                 GDresult,
    input  logic                 ResolveValid,
    input  logic                 BranchTaken,
    output logic                 Prediction,
    output logic                 PredictionValid,
    output logic                 Busy,
    output logic [HIST_BITS-1:0] GlobalHistory,
    output logic [MISP_BITS-1:0] MispredictCount
);

    chooser_state_t r_state;
    chooser_state_t w_next_state;

    logic                 w_accept;
    logic                 w_resolve;
    logic                 w_update;

    logic [HIST_BITS-1:0] r_idx;
    logic                 r_ld;
    logic                 r_gd;
    logic                 r_pred;
    logic                 r_taken;
    logic [HIST_BITS-1:0] r_hist;
    logic [MISP_BITS-1:0] r_misp;

    logic                 w_sel_gd;
    logic                 w_pht_we;
    logic                 w_pht_inc;

    // The table is read with the live history at predict time and written
    // with the index latched then, so a transaction always trains the entry it used.
    choice_pht #(
        .HIST_BITS (HIST_BITS),
        .CNT_BITS  (CNT_BITS)
    ) u_pht (
        .i_clock  (clock),
        .i_rst_n  (reset),
        .i_rd_idx (r_hist),
        .o_rd_msb (w_sel_gd),
        .i_wr_en  (w_pht_we),
        .i_wr_idx (r_idx),
        .i_wr_inc (w_pht_inc)
    );

    // Only train when the components disagreed; move toward whichever was right.
    assign w_pht_we  = w_update && (r_ld != r_gd);
    assign w_pht_inc = (r_gd == r_taken);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_resolve    = 1'b0;
        w_update     = 1'b0;
        case (r_state)
            IDLE: begin
                // A resolve arriving here (even alongside PredValid) has no
                // transaction to belong to and is dropped.
                if (PredValid) begin
                    w_accept     = 1'b1;
                    w_next_state = WAIT_RESOLVE;
                end
            end
            WAIT_RESOLVE: begin
                if (ResolveValid) begin
                    w_resolve    = 1'b1;
                    w_next_state = UPDATE;
                end
            end
            UPDATE: begin
                w_update     = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Inputs are sampled only under their valid pulses, so X outside those
    // pulses never reaches state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx   <= '0;
            r_ld    <= 1'b0;
            r_gd    <= 1'b0;
            r_pred  <= 1'b0;
            r_taken <= 1'b0;
            r_hist  <= '0;
            r_misp  <= '0;
        end else begin
            if (w_accept) begin
                r_idx  <= r_hist;
                r_ld   <= LDresult;
                r_gd   <= GDresult;
                r_pred <= w_sel_gd ? GDresult : LDresult;
            end
            if (w_resolve) begin
                r_taken <= BranchTaken;
            end
            if (w_update) begin
                r_hist <= {r_hist[HIST_BITS-2:0], r_taken};
                if ((r_pred != r_taken) && (r_misp != {MISP_BITS{1'b1}})) begin
                    r_misp <= r_misp + MISP_BITS'(1);
                end
            end
        end
    end

    assign Prediction      = r_pred;
    assign PredictionValid = (r_state != IDLE);
    assign Busy            = (r_state != IDLE);
    assign GlobalHistory   = r_hist;
    assign MispredictCount = r_misp;

endmodule
